// File: rtl/word_capture_pkg.sv
// word_capture_pkg
// Shared definitions for the word_capture FIFO: default word width and
// depth, the pointer width that goes with the default depth, and the
// status-state enum used by the occupancy FSM.
package word_capture_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_DEPTH = 4;

    // Pointer width for the default depth. Instances with a different
    // DEPTH derive their own width the same way ($clog2 of the depth).
    localparam int PTR_WIDTH = $clog2(DEFAULT_DEPTH);

    // Occupancy status: no words, some words, every entry used.
    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_PARTIAL = 2'd1,
        ST_FULL    = 2'd2
    } status_t;

endpackage

// File: rtl/word_capture_mem.sv
// capture_mem
// DEPTH x WIDTH storage array for word_capture.
// Ports:
//   clk      - write clock (rising edge)
//   wr_en    - write strobe, stores wr_data at wr_addr on the rising edge
//   wr_addr  - write index
//   wr_data  - write word
//   rd_addr  - read index
//   rd_data  - asynchronous read of the entry at rd_addr
// The array is deliberately not reset: only the pointers decide which
// entries hold valid data.
module capture_mem #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Combinational read gives first-word fall-through at the head.
    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/word_capture.sv
// word_capture
// Small first-word fall-through FIFO that captures a producer stream with
// no backpressure. Words offered while the FIFO is full (and nothing is
// leaving) are dropped and flagged by a sticky overflow bit. A running
// XOR checksum covers every accepted word.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   in_valid    - producer offers in_data this cycle
//   in_data     - producer word
//   out_valid   - head word available on out_data
//   out_data    - head word (meaningful only while out_valid=1)
//   out_ready   - consumer takes the head word
//   count       - number of stored words
//   full        - all DEPTH entries used
//   overflow    - sticky: at least one word was dropped
//   ovf_clr     - clears overflow (a simultaneous drop wins)
//   checksum    - XOR of all accepted words since reset
module word_capture
    import word_capture_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic [WIDTH-1:0]       in_data,
    output logic                   out_valid,
    output logic [WIDTH-1:0]       out_data,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   overflow,
    input  logic                   ovf_clr,
    output logic [WIDTH-1:0]       checksum
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    status_t          state;
    status_t          state_next;
    logic [AW-1:0]    head_ptr;
    logic [AW-1:0]    tail_ptr;
    logic [CW-1:0]    count_q;
    logic             overflow_q;
    logic [WIDTH-1:0] checksum_q;

    logic push;
    logic pop;
    logic drop;

    // Status outputs come straight from the FSM state.
    assign out_valid = (state != ST_EMPTY);
    assign full      = (state == ST_FULL);
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign checksum  = checksum_q;

    // A full FIFO still accepts a word when the head leaves on the same edge.
    assign pop  = out_valid && out_ready;
    assign push = in_valid && (!full || pop);
    assign drop = in_valid && !push;

    capture_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (tail_ptr),
        .wr_data (in_data),
        .rd_addr (head_ptr),
        .rd_data (out_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Push and pop together leave the state untouched; single-sided
    // moves change state only at the occupancy boundaries.
    always_comb begin
        state_next = state;
        unique case (state)
            ST_EMPTY: begin
                if (push) begin
                    state_next = ST_PARTIAL;
                end
            end
            ST_PARTIAL: begin
                if (push && !pop && (count_q == CW'(DEPTH - 1))) begin
                    state_next = ST_FULL;
                end else if (pop && !push && (count_q == CW'(1))) begin
                    state_next = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (pop && !push) begin
                    state_next = ST_PARTIAL;
                end
            end
            default: state_next = ST_EMPTY;
        endcase
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                tail_ptr <= tail_ptr + AW'(1);
            end
            if (pop) begin
                head_ptr <= head_ptr + AW'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CW'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

    // A drop on the same edge as ovf_clr keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
            checksum_q <= '0;
        end else begin
            if (drop) begin
                overflow_q <= 1'b1;
            end else if (ovf_clr) begin
                overflow_q <= 1'b0;
            end
            if (push) begin
                checksum_q <= checksum_q ^ in_data;
            end
        end
    end

endmodule

// File: doc/word_capture.md
WORD_CAPTURE -- requirements
Module: word_capture

Interface
REQ-001 Parameter WIDTH, default 32: data word width in bits.
REQ-002 Parameter DEPTH, default 4: FIFO entries; SHALL be a power of two, at least 2.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 in_valid  input  1  producer strobe; the word is offered this cycle (no backpressure to producer).
REQ-006 in_data  input  WIDTH  producer word, sampled when in_valid=1.
REQ-007 out_valid  output  1  head word available.
REQ-008 out_data  output  WIDTH  head word; defined only while out_valid=1.
REQ-009 out_ready  input  1  consumer accepts head word.
REQ-010 count  output  log2(DEPTH)+1  number of stored words.
REQ-011 full  output  1  count==DEPTH.
REQ-012 overflow  output  1  sticky flag: a word was dropped.
REQ-013 ovf_clr  input  1  clears overflow.
REQ-014 checksum  output  WIDTH  running XOR of every accepted word.

Function
REQ-015 pop SHALL equal out_valid && out_ready; push SHALL equal in_valid && (!full || pop).
REQ-016 A pushed word SHALL be written at the tail on the edge where push=1; out_valid SHALL assert the following cycle when the FIFO was empty (1-cycle latency).
REQ-017 out_data SHALL be the head entry, driven combinationally from storage (first-word fall-through), with no bubble between consecutive pops.
REQ-018 Words SHALL leave in arrival order; head/tail pointers SHALL wrap modulo DEPTH.
REQ-019 Status FSM SHALL have states EMPTY, PARTIAL, FULL: EMPTY->PARTIAL on push only; PARTIAL->FULL on push only with count==DEPTH-1; PARTIAL->EMPTY on pop only with count==1; FULL->PARTIAL on pop only; push+pop together SHALL hold state and count.
REQ-020 out_valid SHALL be 0 exactly in EMPTY; full SHALL be 1 exactly in FULL.
REQ-021 Push while empty with out_ready=1 SHALL NOT bypass: the word appears on out_data the next cycle.
REQ-022 in_valid=1 while full and pop=0 SHALL drop the word, leave storage, count and checksum unchanged, and set overflow on that edge.
REQ-023 In FULL with pop=1 and in_valid=1, the new word SHALL be accepted and count SHALL stay DEPTH.
REQ-024 overflow SHALL clear on the edge where ovf_clr=1, unless a drop occurs on that same edge, in which case set SHALL win.
REQ-025 checksum SHALL update to checksum XOR in_data on each push; dropped words SHALL NOT contribute.
REQ-026 out_ready while out_valid=0 SHALL have no effect.

Reset
REQ-027 rst_n=0 SHALL immediately force: state EMPTY, pointers 0, count 0, out_valid 0, full 0, overflow 0, checksum 0.
REQ-028 Storage contents SHALL NOT be reset; out_data is don't-care during and after reset until the first push.
REQ-029 Reset mid-operation SHALL discard all stored words; the first push after release SHALL be the head.

Structure
REQ-030 Package word_capture_pkg SHALL hold the WIDTH/DEPTH defaults, the pointer-width constant, and the status-state enum.
REQ-031 Storage SHALL be a sub-module capture_mem (DEPTH x WIDTH, one synchronous write port, one asynchronous read port); pointers, FSM, flags and checksum SHALL stay in word_capture.

Verification
REQ-032 Single word: push 32'hDEAD_BEEF with out_ready=0 -> next cycle out_valid=1, out_data=32'hDEAD_BEEF, count=1, checksum=32'hDEAD_BEEF.
REQ-033 Fill: push 1,2,3,4 then 5 with out_ready=0 -> full=1, count=4, overflow=1, checksum=32'h0000_0004; pop four -> 1,2,3,4 in order, then out_valid=0.
REQ-034 Full push+pop: at full with 1..4, in_valid=1, data 9, out_ready=1 -> 1 leaves, count stays 4, overflow stays 0, later drain order 2,3,4,9.
REQ-035 Wrap: stream 10 words with out_ready=1 continuously -> output equals input order, count never exceeds 1, pointers wrap twice.
REQ-036 Overflow clear race: drop at full with ovf_clr=1 on the same edge -> overflow=1; ovf_clr next cycle with no drop -> overflow=0.
REQ-037 Reset mid-stream: three words stored, pulse rst_n low between edges -> out_valid=0, count=0, checksum=0 immediately; next push of 32'h0000_00AA appears as the head.
